// File: rtl/register_file.sv
// rtl/register_file.sv - 31x n-bit register file with XZR, post-reset clear sequence and Ready flag.
// Optional write-through read bypass when REGFILE_BYPASS_EN is defined.
module register_file #(
   parameter int n = 64
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [4:0]   RA,
   input  logic [4:0]   RB,
   input  logic [4:0]   RW,
   input  logic [n-1:0] BusW,
   input  logic         RegWr,
   output logic [n-1:0] BusA,
   output logic [n-1:0] BusB,
   output logic         Ready
);

   typedef enum logic {CLEAR, RUN} state_t;

   localparam logic [4:0] XZR = 5'd31;

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [n-1:0] regs_q [31];
   logic [n-1:0] regs_d [31];
   logic [n-1:0] rd_a, rd_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      regs_d  = regs_q;
      case (state_q)
         CLEAR: begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 5'd1;
            if (cnt_q == 5'd30) state_d = RUN;
         end
         RUN: begin
            if (RegWr && (RW != XZR)) regs_d[RW] = BusW;
         end
         default: state_d = CLEAR;
      endcase
   end

   // Reset only restarts the FSM; storage is zeroed by the clear walk, and
   // Reset blocks any write landing on the same edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= CLEAR;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
      end
   end

   always_comb begin
      rd_a = (RA == XZR) ? '0 : regs_q[RA];
      rd_b = (RB == XZR) ? '0 : regs_q[RB];
`ifdef REGFILE_BYPASS_EN
      if (RegWr && (RW != XZR) && (RW == RA)) rd_a = BusW;
      if (RegWr && (RW != XZR) && (RW == RB)) rd_b = BusW;
`endif
   end

   // Storage is undefined until cleared, so reads are masked outside RUN.
   assign BusA  = (state_q == RUN) ? rd_a : '0;
   assign BusB  = (state_q == RUN) ? rd_b : '0;
   assign Ready = (state_q == RUN);

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file.
module tb_register_file;

   logic        Clk;
   logic        Reset;
   logic [4:0]  RA, RB, RW;
   logic [63:0] BusW;
   logic        RegWr;
   logic [63:0] BusA, BusB;
   logic        Ready;

   int checks   = 0;
   int failures = 0;

   register_file #(.n(64)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .RA    (RA),
      .RB    (RB),
      .RW    (RW),
      .BusW  (BusW),
      .RegWr (RegWr),
      .BusA  (BusA),
      .BusB  (BusB),
      .Ready (Ready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] addr, input logic [63:0] data);
      RW = addr; BusW = data; RegWr = 1'b1;
      tick();
      RegWr = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;

      tick(); tick();
      check("reset_ready", {63'd0, Ready}, 64'd0);
      check("reset_busa", BusA, 64'd0);
      check("reset_busb", BusB, 64'd0);

      Reset = 1'b0;
      RA = 5'd2; RB = 5'd2;
      for (int e = 1; e <= 31; e++) begin
         tick();
         check($sformatf("clr1_ready_e%0d", e), {63'd0, Ready}, (e == 31) ? 64'd1 : 64'd0);
         if (e < 31) check($sformatf("clr1_busa_e%0d", e), BusA, 64'd0);
      end

      for (int r = 0; r <= 30; r++) begin
         RA = r[4:0]; RB = 5'(30 - r);
         #1;
         check($sformatf("zero_a_x%0d", r), BusA, 64'd0);
         check($sformatf("zero_b_x%0d", 30 - r), BusB, 64'd0);
      end

      write_reg(5'd5, 64'h0000_0000_0000_1234);
      RA = 5'd5; RB = 5'd5; #1;
      check("x5_busa", BusA, 64'h1234);
      check("x5_busb", BusB, 64'h1234);
      RA = 5'd4; RB = 5'd6; #1;
      check("x4_untouched", BusA, 64'd0);
      check("x6_untouched", BusB, 64'd0);

      RA = 5'd31; RW = 5'd31; BusW = 64'hFFFF_FFFF_FFFF_FFFF; RegWr = 1'b1; #1;
      check("xzr_before", BusA, 64'd0);
      tick();
      RegWr = 1'b0;
      check("xzr_after", BusA, 64'd0);

      write_reg(5'd7, 64'hAA);
      RA = 5'd7; RB = 5'd7; RW = 5'd7; BusW = 64'h55; RegWr = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
      check("same_cycle_a", BusA, 64'h55);
      check("same_cycle_b", BusB, 64'h55);
`else
      check("same_cycle_a", BusA, 64'hAA);
      check("same_cycle_b", BusB, 64'hAA);
`endif
      tick();
      RegWr = 1'b0;
      check("after_write_x7", BusA, 64'h55);

      write_reg(5'd10, 64'h99);
      write_reg(5'd3, 64'h33);
      RA = 5'd10; RB = 5'd3; #1;
      check("x10_pre", BusA, 64'h99);
      check("x3_pre", BusB, 64'h33);

      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("restart_ready", {63'd0, Ready}, 64'd0);
      check("restart_busa", BusA, 64'd0);
      for (int e = 1; e <= 5; e++) tick();
      RW = 5'd3; BusW = 64'hDEAD_BEEF; RegWr = 1'b1;
      tick();
      RegWr = 1'b0;
      for (int e = 7; e <= 31; e++) begin
         tick();
         check($sformatf("clr2_ready_e%0d", e), {63'd0, Ready}, (e == 31) ? 64'd1 : 64'd0);
      end
      RA = 5'd3; RB = 5'd10; #1;
      check("x3_cleared", BusA, 64'd0);
      check("x10_cleared", BusB, 64'd0);

      write_reg(5'd8, 64'h88);
      RW = 5'd8; BusW = 64'h77; RegWr = 1'b1; Reset = 1'b1;
      tick(); tick(); tick();
      Reset = 1'b0; RegWr = 1'b0; RA = 5'd2; RB = 5'd8;
      for (int e = 1; e <= 31; e++) begin
         tick();
         check($sformatf("clr3_ready_e%0d", e), {63'd0, Ready}, (e == 31) ? 64'd1 : 64'd0);
         if (e < 31) check($sformatf("clr3_busa_e%0d", e), BusA, 64'd0);
      end
      check("x8_after_reset", BusB, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
